// File: rtl/close_result_bcd_pkg.sv
// Shared constants and state encoding for the result-closing BCD converter.
package close_result_bcd_pkg;

  localparam int DATA_W   = 12;
  localparam int BCD_W    = 16;
  localparam int ITER_N   = 12;
  localparam int DIFF_MAX = 9;
  localparam int CNT_W    = 4;
  localparam int DIFF_W   = 4;

  // Bit positions inside the one-hot state vector; Qs exposes it as-is.
  localparam int ST_IDLE_BIT = 0;
  localparam int ST_CONV_BIT = 1;
  localparam int ST_OUT_BIT  = 2;
  localparam int ST_ACKW_BIT = 3;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_CONV = 4'b0010,
    S_OUT  = 4'b0100,
    S_ACKW = 4'b1000
  } state_t;

endpackage

// File: rtl/close_result_bcd_dabble_nibble.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module dabble_nibble (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3 correction for digits that would overflow past 9 after shifting.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/close_result_bcd.sv
// Captures the adjusted A from the upstream adjuster, converts it to four BCD
// digits with a 12-step double-dabble, and reports how far A sits below B.
//
// state | meaning
// IDLE  | waiting for upstream Done, last result still on the outputs
// CONV  | one double-dabble step per clock, 12 steps
// OUT   | result valid, waiting for the consumer to take it (Rd)
// ACKW  | acknowledging upstream until it drops Done
module close_result_bcd
  import close_result_bcd_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Done,
  input  logic [DATA_W-1:0]   Ain,
  input  logic [DATA_W-1:0]   Bref,
  output logic                Ack,
  input  logic                Rd,
  output logic                Valid,
  output logic [BCD_W-1:0]    Bcd,
  output logic [DIFF_W-1:0]   Diff,
  output logic                OvErr,
  output logic [3:0]          Qs
);

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_fix;
  logic [DATA_W-1:0]  a_sh;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W:0]    sub;
  logic               last_step;
  logic [BCD_W-1:0]   acc_shift;

  for (genvar g = 0; g < BCD_W / 4; g++) begin : g_dabble
    dabble_nibble u_nib (
      .din  (acc[4*g +: 4]),
      .dout (acc_fix[4*g +: 4])
    );
  end

  // One extra bit makes A > B show up as a set sign bit.
  assign sub       = {1'b0, Bref} - {1'b0, Ain};
  assign last_step = (cnt == CNT_W'(ITER_N - 1));
  assign acc_shift = {acc_fix[BCD_W-2:0], a_sh[DATA_W-1]};

  // Outputs decode single state flops directly, so they cannot glitch.
  assign Qs    = state;
  assign Valid = state[ST_OUT_BIT];
  assign Ack   = state[ST_ACKW_BIT];

  // Next-state selection; Done only matters in IDLE/ACKW, Rd only in OUT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (Done)      state_nxt = S_CONV;
      S_CONV: if (last_step) state_nxt = S_OUT;
      S_OUT:  if (Rd)        state_nxt = S_ACKW;
      S_ACKW: if (!Done)     state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // State register plus capture, conversion and result datapath.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      acc   <= '0;
      a_sh  <= '0;
      cnt   <= '0;
      Bcd   <= '0;
      Diff  <= '0;
      OvErr <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (Done) begin
            a_sh <= Ain;
            acc  <= '0;
            cnt  <= '0;
            if (sub[DATA_W] || (sub > (DATA_W+1)'(DIFF_MAX))) begin
              OvErr <= 1'b1;
              Diff  <= '1;
            end else begin
              OvErr <= 1'b0;
              Diff  <= sub[DIFF_W-1:0];
            end
          end
        end
        S_CONV: begin
          acc  <= acc_shift;
          a_sh <= {a_sh[DATA_W-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
          if (last_step) Bcd <= acc_shift;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_close_result_bcd.sv
// Directed and random transactions against a decimal/arithmetic reference.
module tb_close_result_bcd;

  logic        Clk = 1'b0;
  logic        Reset, Done, Rd;
  logic [11:0] Ain, Bref;
  logic        Ack, Valid, OvErr;
  logic [15:0] Bcd;
  logic [3:0]  Diff, Qs;

  int n_checks = 0;
  int n_fail   = 0;

  close_result_bcd dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Done  (Done),
    .Ain   (Ain),
    .Bref  (Bref),
    .Ack   (Ack),
    .Rd    (Rd),
    .Valid (Valid),
    .Bcd   (Bcd),
    .Diff  (Diff),
    .OvErr (OvErr),
    .Qs    (Qs)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int a);
    int v;
    v = ((a / 1000) % 10) * 4096 + ((a / 100) % 10) * 256 + ((a / 10) % 10) * 16 + (a % 10);
    return v[15:0];
  endfunction

  function automatic void ref_diff(input int a, input int b, output logic [3:0] d, output logic ov);
    int x;
    x = b - a;
    if (x < 0 || x > 9) begin
      d  = 4'hF;
      ov = 1'b1;
    end else begin
      d  = x[3:0];
      ov = 1'b0;
    end
  endfunction

  // One full handshake. Valid is expected on the 13th edge counting the
  // capture edge as the first (12 conversion edges follow the capture).
  task automatic run_txn(input int a, input int b, input int rd_wait, input int done_hold,
                         input bit toggle_done);
    logic [15:0] eb;
    logic [3:0]  ed;
    logic        eo;
    eb = ref_bcd(a);
    ref_diff(a, b, ed, eo);
    @(negedge Clk);
    Ain  = a[11:0];
    Bref = b[11:0];
    Done = 1'b1;
    Rd   = 1'b0;
    @(negedge Clk);
    check("qs_conv", 16'(Qs), 16'h0002);
    check("diff_cap", 16'(Diff), 16'(ed));
    check("ov_cap", 16'(OvErr), 16'(eo));
    Done = 1'b0;
    for (int i = 1; i < 12; i++) begin
      @(negedge Clk);
      if (toggle_done) begin
        Done = ~Done;
        Ain  = ~Ain;
      end
    end
    check("valid_early", 16'(Valid), 16'h0000);
    Done = 1'b0;
    @(negedge Clk);
    check("valid_on", 16'(Valid), 16'h0001);
    check("qs_out", 16'(Qs), 16'h0004);
    check("bcd", Bcd, eb);
    check("diff", 16'(Diff), 16'(ed));
    check("overr", 16'(OvErr), 16'(eo));
    if (rd_wait > 0) begin
      repeat (rd_wait) @(negedge Clk);
      check("valid_hold", 16'(Valid), 16'h0001);
      check("bcd_hold", Bcd, eb);
    end
    Done = (done_hold > 0);
    Rd   = 1'b1;
    @(negedge Clk);
    check("ack_on", 16'(Ack), 16'h0001);
    check("valid_off", 16'(Valid), 16'h0000);
    check("qs_ackw", 16'(Qs), 16'h0008);
    Rd = 1'b0;
    if (done_hold > 0) begin
      repeat (done_hold) @(negedge Clk);
      check("qs_ackw_hold", 16'(Qs), 16'h0008);
    end
    Done = 1'b0;
    @(negedge Clk);
    check("qs_idle", 16'(Qs), 16'h0001);
    check("ack_off", 16'(Ack), 16'h0000);
    check("bcd_keep", Bcd, eb);
    check("diff_keep", 16'(Diff), 16'(ed));
  endtask

  initial begin
    int a, b;
    Reset = 1'b1;
    Done  = 1'b0;
    Rd    = 1'b0;
    Ain   = '0;
    Bref  = '0;
    repeat (2) @(negedge Clk);
    check("rst_qs", 16'(Qs), 16'h0001);
    check("rst_valid", 16'(Valid), 16'h0000);
    check("rst_ack", 16'(Ack), 16'h0000);
    check("rst_bcd", Bcd, 16'h0000);
    check("rst_diff", 16'(Diff), 16'h0000);
    check("rst_ov", 16'(OvErr), 16'h0000);
    Reset = 1'b0;

    run_txn(1234, 1240, 0, 0, 1'b0);
    run_txn(4095, 4095, 0, 0, 1'b0);
    run_txn(100, 150, 0, 0, 1'b0);
    run_txn(200, 150, 0, 0, 1'b0);
    run_txn(567, 576, 20, 5, 1'b0);

    // Rd outside OUT must not move the FSM; idle keeps the last result.
    @(negedge Clk);
    Rd = 1'b1;
    repeat (3) @(negedge Clk);
    check("rd_idle_qs", 16'(Qs), 16'h0001);
    check("idle_bcd", Bcd, ref_bcd(567));
    Rd = 1'b0;

    // Reset after six conversion steps abandons the result.
    @(negedge Clk);
    Ain  = 12'd3071;
    Bref = 12'd3075;
    Done = 1'b1;
    @(negedge Clk);
    Done = 1'b0;
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_qs", 16'(Qs), 16'h0001);
    check("mid_rst_valid", 16'(Valid), 16'h0000);
    check("mid_rst_ack", 16'(Ack), 16'h0000);
    check("mid_rst_bcd", Bcd, 16'h0000);
    check("mid_rst_diff", 16'(Diff), 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check("post_rst_idle", 16'(Qs), 16'h0001);
    check("post_rst_valid", 16'(Valid), 16'h0000);
    run_txn(0, 9, 0, 0, 1'b0);

    run_txn(2468, 2470, 1, 0, 1'b1);

    for (int k = 0; k < 30; k++) begin
      a = int'($urandom_range(4095));
      if ($urandom_range(1) == 1) begin
        b = a + int'($urandom_range(12));
        if (b > 4095) b = 4095;
      end else begin
        b = int'($urandom_range(4095));
      end
      run_txn(a, b, int'($urandom_range(3)), int'($urandom_range(2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/close_result_bcd.md
CLOSE_RESULT_BCD -- requirements
Module: close_result_bcd

Interface
REQ-001 SHALL have port Clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port Done, input, 1 bit: upstream adjuster done-state indicator (driven by its Qd).
REQ-004 SHALL have port Ain, input, 12 bits: adjusted A from upstream, unsigned.
REQ-005 SHALL have port Bref, input, 12 bits: target B, held stable by the source while Done=1.
REQ-006 SHALL have port Ack, output, 1 bit: acknowledge to upstream.
REQ-007 SHALL have port Rd, input, 1 bit: downstream consumer accepts the result.
REQ-008 SHALL have port Valid, output, 1 bit: result available.
REQ-009 SHALL have port Bcd, output, 16 bits: A as four BCD digits; [15:12] is thousands, [3:0] is ones.
REQ-010 SHALL have port Diff, output, 4 bits: Bref minus A, binary.
REQ-011 SHALL have port OvErr, output, 1 bit: result outside the contract (A>B or B-A>9).
REQ-012 SHALL have port Qs, output, 4 bits: one-hot state {Qack,Qout,Qconv,Qidle}.

Function
REQ-013 SHALL implement a one-hot FSM with states IDLE, CONV, OUT and ACKW.
REQ-014 In IDLE with Done=1, SHALL, on the next edge, latch Ain, clear the 16-bit BCD accumulator, clear the 4-bit iteration counter, compute Bref-Ain, and go to CONV.
REQ-015 In IDLE with Done=0, SHALL hold all registers.
REQ-016 Diff/OvErr rule: the subtraction SHALL be 13 bits wide.
- If the result is negative or exceeds 9: OvErr=1 and Diff=4'hF.
- Otherwise: OvErr=0 and Diff equals the low 4 bits of the result.
REQ-017 CONV SHALL perform one double-dabble step per clock:
- first, add 3 to every accumulator nibble that is 5 or greater;
- then shift {accumulator, A-shift} left by 1, taking A MSB first.
REQ-018 CONV SHALL last exactly 12 clocks; the edge that performs step 12 (counter==11) SHALL move the FSM to OUT and load Bcd.
REQ-019 Valid SHALL be 1 exactly when the state is OUT; first assertion is 13 clocks after the edge that sampled Done=1 in IDLE.
REQ-020 In OUT, Bcd, Diff and OvErr SHALL remain stable; Rd=1 SHALL move the FSM to ACKW on the next edge, and Rd=0 SHALL hold OUT indefinitely.
REQ-021 Ack SHALL be 1 exactly when the state is ACKW, as a registered state decode with no glitches.
REQ-022 In ACKW, Done=0 SHALL move the FSM to IDLE on the next edge; Done=1 SHALL hold ACKW.
REQ-023 Done SHALL be ignored in CONV and OUT; Rd SHALL be ignored outside OUT.
REQ-024 Bcd, Diff and OvErr SHALL retain the last result through ACKW and IDLE until the next capture overwrites them.
REQ-025 Maximum input A=4095 SHALL convert correctly, with no BCD overflow in 16 bits.

Reset
REQ-026 Reset=1 SHALL force, asynchronously:
- state to IDLE, so Qs=4'b0001;
- Valid=0 and Ack=0;
- Bcd=16'h0000, Diff=4'h0 and OvErr=0;
- counter and accumulator to 0.
REQ-027 Reset asserted mid-CONV or mid-OUT SHALL abandon the result; after release, the block SHALL wait in IDLE for Done.

Structure
REQ-028 A shared package SHALL hold the state one-hot encodings, the data width (12), the BCD width (16), the iteration count (12) and the Diff limit (9).
REQ-029 The nibble correction (add 3 if the nibble is 5 or greater) SHALL be one combinational sub-module, dabble_nibble, instantiated four times.
REQ-030 The top SHALL contain the FSM and datapath in one clocked process.

Verification
REQ-031 Ain=1234, Bref=1240, Done=1, Rd=1 on Valid -> Bcd=16'h1234, Diff=6, OvErr=0; Valid at clock 13; Ack rises the cycle after Rd.
REQ-032 Ain=4095, Bref=4095 -> Bcd=16'h4095, Diff=0, OvErr=0.
REQ-033 Ain=100, Bref=150 -> Bcd=16'h0100, Diff=4'hF, OvErr=1. Also Ain=200, Bref=150 -> OvErr=1, Diff=4'hF.
REQ-034 Rd held 0 for 20 clocks in OUT -> Valid remains 1 and Bcd is unchanged. Done held 1 for 5 clocks after Ack -> FSM stays in ACKW, then reaches IDLE one edge after Done=0.
REQ-035 Reset pulsed at CONV step 6 -> Qs=4'b0001, Valid=0, Ack=0, Bcd=0. Then Ain=0, Bref=9 -> Bcd=16'h0000, Diff=9.
REQ-036 Done toggled during CONV -> no restart; the result matches the first capture.
